mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_seq_pkg.sv | 45 ++++
 rtl/mult_ctrl_decode.sv | 26 ++
 rtl/mult_sequencer.sv | 101 ++++++++++
 tb/tb_mult_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the multiply sequencer: state codes, ctrl bit
// positions, per-state ctrl words and the default iteration limit.
package mult_seq_pkg;

   // State codes double as the 7-seg debug code, so values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LD_M = 3'd1,
      ST_LD_Q = 3'd2,
      ST_TEST = 3'd3,
      ST_ADD  = 3'd4,
      ST_ACC  = 3'd5,
      ST_DONE = 3'd6,
      ST_ERR  = 3'd7
   } state_t;

   localparam int CTRL_W = 7;

   // Bit positions inside the ctrl word.
   localparam int CTRL_Q_LD  = 6;  // load Q from input bus
   localparam int CTRL_R_LD  = 5;  // load R from ALU result
   localparam int CTRL_Q_DEC = 4;  // decrement Q
   localparam int CTRL_ADD   = 3;  // ALU computes R + M
   localparam int CTRL_R_CLR = 2;  // clear R
   localparam int CTRL_M_LD  = 1;  // load M from input bus
   localparam int CTRL_DISP  = 0;  // result display enable

   // Per-state ctrl words. ADD and ACC are split so that the ALU strobe
   // and the R load never share a cycle, and R clear only occurs in LD_M.
   localparam logic [CTRL_W-1:0] CTRL_IDLE = 7'b000_0000;
   localparam logic [CTRL_W-1:0] CTRL_LD_M = 7'b000_0110;
   localparam logic [CTRL_W-1:0] CTRL_LD_Q = 7'b100_0000;
   localparam logic [CTRL_W-1:0] CTRL_TEST = 7'b000_0000;
   localparam logic [CTRL_W-1:0] CTRL_ADDS = 7'b000_1000;
   localparam logic [CTRL_W-1:0] CTRL_ACC  = 7'b011_0000;
   localparam logic [CTRL_W-1:0] CTRL_DONE = 7'b000_0001;
   localparam logic [CTRL_W-1:0] CTRL_ERR  = 7'b000_0000;

   // Default abort threshold for the add loop.
   localparam int MAX_ITER_DEFAULT = 15;

   // The iteration counter is 4 bits wide and saturates at this value.
   localparam logic [3:0] ITER_SAT = 4'd15;

endpackage

// File: rtl/mult_ctrl_decode.sv
// Pure state-to-ctrl decode; no inputs other than the state register,
// which keeps the outputs strictly Moore.
module mult_ctrl_decode
   import mult_seq_pkg::*;
(
   input  state_t              state,
   output logic [CTRL_W-1:0]   ctrl
);

   // Look up the ctrl word that the current state presents to the datapath.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         ST_IDLE: ctrl = CTRL_IDLE;
         ST_LD_M: ctrl = CTRL_LD_M;
         ST_LD_Q: ctrl = CTRL_LD_Q;
         ST_TEST: ctrl = CTRL_TEST;
         ST_ADD:  ctrl = CTRL_ADDS;
         ST_ACC:  ctrl = CTRL_ACC;
         ST_DONE: ctrl = CTRL_DONE;
         ST_ERR:  ctrl = CTRL_ERR;
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for a shift-free repeated-add multiplier: loads M and Q,
// adds M into R once per Q count, and reports done or an iteration abort.
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int MAX_ITER = MAX_ITER_DEFAULT
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ack,
   input  logic              q_nz,
   output logic [CTRL_W-1:0] ctrl,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        iter,
   output logic [2:0]        state
);

   localparam logic [3:0] ITER_LIMIT = 4'(MAX_ITER);

   state_t     state_reg;
   state_t     state_next;
   logic [3:0] iter_reg;

   // State register; reset forces IDLE immediately, which also zeroes ctrl.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic. start and ack are only looked at in the states that
   // accept them, so stray pulses elsewhere are dropped without queuing.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_LD_M;
         ST_LD_M: state_next = ST_LD_Q;
         ST_LD_Q: state_next = ST_TEST;
         ST_TEST: begin
            if (!q_nz) begin
               state_next = ST_DONE;
            end else if (iter_reg == ITER_LIMIT) begin
               state_next = ST_ERR;
            end else begin
               state_next = ST_ADD;
            end
         end
         ST_ADD:  state_next = ST_ACC;
         ST_ACC:  state_next = ST_TEST;
         ST_DONE: if (ack) state_next = ST_IDLE;
         ST_ERR:  if (ack) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state register alone.
   always_comb begin
      busy = 1'b1;
      done = 1'b0;
      err  = 1'b0;
      case (state_reg)
         ST_IDLE: busy = 1'b0;
         ST_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         ST_ERR: begin
            busy = 1'b0;
            err  = 1'b1;
         end
         default: busy = 1'b1;
      endcase
   end

   // Iteration counter: cleared when an operation is launched, bumped on
   // each ACC->TEST step, and otherwise held so the last count stays visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iter_reg <= 4'd0;
      end else if (state_reg == ST_IDLE && start) begin
         iter_reg <= 4'd0;
      end else if (state_reg == ST_ACC && iter_reg != ITER_SAT) begin
         iter_reg <= iter_reg + 4'd1;
      end
   end

   mult_ctrl_decode u_decode (
      .state (state_reg),
      .ctrl  (ctrl)
   );

   assign iter  = iter_reg;
   assign state = state_reg;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer paired with a behavioural 4-bit R/M/Q datapath.
module tb_mult_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADD  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       ack = 1'b0;
   logic       q_nz;
   logic [6:0] ctrl;
   logic       busy, done, err;
   logic [3:0] iter;
   logic [2:0] state;

   logic [3:0] bus = 4'd0;
   logic       force_nz = 1'b0;

   // behavioural datapath registers
   logic [3:0] m_d = 4'd0, q_d = 4'd0, r_d = 4'd0, alu_d = 4'd0;

   int checks = 0;
   int errors = 0;
   int add_cnt = 0;
   int act_cnt = 0;
   int excl_bad = 0;

   mult_sequencer #(.MAX_ITER(15)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .ack   (ack),
      .q_nz  (q_nz),
      .ctrl  (ctrl),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .iter  (iter),
      .state (state)
   );

   always #5 clk = ~clk;

   assign q_nz = force_nz | (q_d != 4'd0);

   // datapath acts on the ctrl word present during the cycle ending at this edge
   always @(posedge clk) begin
      if (ctrl[1]) m_d <= bus;
      if (ctrl[2]) r_d <= 4'd0;
      if (ctrl[6]) q_d <= bus;
      if (ctrl[3]) alu_d <= r_d + m_d;
      if (ctrl[5]) r_d <= alu_d;
      if (ctrl[4]) q_d <= q_d - 4'd1;
   end

   // activity monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ctrl[3]) add_cnt++;
      if (ctrl != 7'd0) act_cnt++;
      if ((ctrl[3] && ctrl[5]) || (ctrl[5] && ctrl[2])) excl_bad++;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Launch an operation; returns just after E1 with Q on the bus.
   task automatic kick(input logic [3:0] m, input logic [3:0] q);
      bus = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      bus = q;
   endtask

   // Count edges until DONE/ERR; optionally pulse start+ack at edge count pulse_at.
   task automatic wait_end(input int pulse_at, output int lat);
      int cnt;
      cnt = 1;
      lat = -1;
      while (cnt < 80 && lat < 0) begin
         if (cnt == pulse_at) begin
            start = 1'b1;
            ack = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         ack = 1'b0;
         cnt++;
         if (state == S_DONE || state == S_ERR) lat = cnt;
      end
      if (lat < 0) check("timeout_end", 0, 1);
   endtask

   typedef struct {
      logic [3:0] m;
      logic [3:0] q;
      int         lat;
      logic [3:0] r;
      logic [3:0] it;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int lat;
      int adds0;
      int act0;
      int n;

      vecs[0] = '{4'd3,  4'd4,  15, 4'd12, 4'd4};
      vecs[1] = '{4'd5,  4'd0,   3, 4'd0,  4'd0};
      vecs[2] = '{4'd15, 4'd15, 48, 4'd1,  4'd15};
      vecs[3] = '{4'd7,  4'd2,   9, 4'd14, 4'd2};
      vecs[4] = '{4'd2,  4'd1,   6, 4'd2,  4'd1};
      vecs[5] = '{4'd9,  4'd3,  12, 4'd11, 4'd3};

      // asynchronous reset, checked before any clock edge
      #1 reset = 1'b0;
      #1;
      check("rst_state", int'(state), 0);
      check("rst_ctrl", int'(ctrl), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_iter", int'(iter), 0);
      #6 reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", int'(state), 0);

      // table-driven multiplications
      for (int i = 0; i < 6; i++) begin
         adds0 = add_cnt;
         kick(vecs[i].m, vecs[i].q);
         wait_end(-1, lat);
         $display("op m=%0d q=%0d lat=%0d r=%0d iter=%0d ctrl=%b",
                  vecs[i].m, vecs[i].q, lat, r_d, iter, ctrl);
         check("lat", lat, vecs[i].lat);
         check("done_state", int'(state), int'(S_DONE));
         check("done_ctrl", int'(ctrl), 1);
         check("done_flag", int'(done), 1);
         check("done_busy", int'(busy), 0);
         check("product", int'(r_d), int'(vecs[i].r));
         check("iter", int'(iter), int'(vecs[i].it));
         check("add_count", add_cnt - adds0, int'(vecs[i].q));
         ack = 1'b1;
         @(posedge clk); #1;
         ack = 1'b0;
         check("ack_idle", int'(state), 0);
         check("iter_hold", int'(iter), int'(vecs[i].it));
      end

      // stuck q_nz -> iteration abort
      force_nz = 1'b1;
      adds0 = add_cnt;
      kick(4'd1, 4'd0);
      wait_end(-1, lat);
      $display("op err-abort lat=%0d iter=%0d err=%0d ctrl=%b", lat, iter, err, ctrl);
      check("err_lat", lat, 48);
      check("err_state", int'(state), int'(S_ERR));
      check("err_flag", int'(err), 1);
      check("err_ctrl", int'(ctrl), 0);
      check("err_busy", int'(busy), 0);
      check("err_iter", int'(iter), 15);
      check("err_adds", add_cnt - adds0, 15);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("err_ignore_start", int'(state), int'(S_ERR));
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      check("err_ack_idle", int'(state), 0);
      force_nz = 1'b0;

      // reset asserted while in ADD
      kick(4'd3, 4'd4);
      n = 0;
      while (state != S_ADD && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_add", int'(state), int'(S_ADD));
      #2 reset = 1'b0;
      #1;
      $display("op reset-in-add state=%0d ctrl=%b busy=%0d", state, ctrl, busy);
      check("midrst_ctrl", int'(ctrl), 0);
      check("midrst_state", int'(state), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_iter", int'(iter), 0);
      #2 reset = 1'b1;
      act0 = act_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("postrst_idle", int'(state), 0);
      check("postrst_quiet", act_cnt - act0, 0);

      // start/ack while busy, then start+ack together in DONE
      kick(4'd2, 4'd2);
      wait_end(2, lat);
      $display("op busy-pulse lat=%0d r=%0d iter=%0d", lat, r_d, iter);
      check("pulse_lat", lat, 9);
      check("pulse_product", int'(r_d), 4);
      start = 1'b1;
      ack = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ack = 1'b0;
      check("both_idle", int'(state), 0);
      act0 = act_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("stay_idle", int'(state), 0);
      check("stay_quiet", act_cnt - act0, 0);
      check("stay_iter", int'(iter), 2);

      check("ctrl_exclusive", excl_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
